data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
Shares the single-port data memory between two requesters: port 0 is the pipeline memory stage, and port 1 is a secondary master such as a program loader or debug/DMA engine. Arbitration uses fixed priority to port 0, with a starvation guard that guarantees port 1 forward progress. Read data returns after a fixed memory latency and is routed back to the owning port through a tag pipeline. The block emits a stall to the pipeline whenever port 0 requests but is not granted.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
READ_LATENCY, 1, cycles from granted read to mem_rdata valid; legal range 1..4
STARVE_LIMIT, 4, consecutive denied port-1 cycles before port 1 is forced; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 access request
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 byte address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 granted this cycle
p0_rvalid  out  1  port 0 read data valid
p0_rdata  out  DATA_W  port 0 read data
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LATENCY cycles after the read address
stall  out  1  p0_req && !p0_gnt

Behaviour:
- Reset (async, active-high):
  - p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we and stall all read 0.
  - rdata outputs are 0.
  - The starvation counter is 0 and the tag pipeline is empty.
  - Gnt and mem_we are forced to 0 while reset is high.
- Grant is combinational in the request cycle; there is at most one grant per cycle.
  - force = (starve_cnt == STARVE_LIMIT) && p1_req.
  - p1_gnt = p1_req && (!p0_req || force).
  - p0_gnt = p0_req && !p1_gnt.
- Mux: mem_addr, mem_we and mem_wdata come from the granted port.
  - mem_we = granted port's we.
  - With no grant, mem_we = 0 and mem_addr holds its last value (don't care).
- Requester rule: req, we, addr and wdata stay stable until gnt is seen. A request is consumed in its grant cycle.
- Writes complete in the grant cycle and never produce rvalid.
- Reads: each grant cycle pushes a tag {valid = granted && !we, owner} into a READ_LATENCY-deep shift register. It advances every cycle (fully pipelined, one new read per cycle).
  - When a tag exits with valid=1, the owner's rvalid pulses for 1 cycle and its rdata = mem_rdata.
  - rdata holds its last value otherwise. The other port's rvalid stays 0.
- Starvation counter (4-bit, saturating at STARVE_LIMIT):
  - Increments when p1_req && !p1_gnt.
  - Clears to 0 on p1_gnt or when !p1_req.
- Simultaneous requests: port 0 wins unless force is set. In a forced cycle stall = 1 and port 0 retries next cycle. After a forced grant the counter clears, so port 0 wins again on the next cycle.
- Back-to-back reads from alternating owners return in grant order with correct owner routing.
- Reset mid-operation flushes the tag pipeline; in-flight reads return no rvalid.
- Memory writes triggered in the same edge as reset assertion are not guaranteed.

Optional Feature:
DM_ARB_STATS_EN
- Defined: adds outputs stat_conflicts (32-bit; counts cycles with p0_req && p1_req) and stat_forced (32-bit; counts forced port-1 grants). Both wrap modulo 2^32 and are reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Port 0 alone: write addr 0x10 data 0xDEADBEEF, then read 0x10 → p0_gnt=1 both cycles, stall=0, p0_rvalid=1 with p0_rdata=0xDEADBEEF exactly READ_LATENCY cycles after the read grant; p1_rvalid stays 0.
- Port 1 alone: reads 0x20, 0x24 back-to-back (mem holds 0x1, 0x2) → two consecutive p1_rvalid pulses with data 0x1 then 0x2.
- Both requesting continuously, STARVE_LIMIT=4 → p0 granted 4 cycles, p1 granted cycle 5 with stall=1, p0 granted cycle 6; pattern repeats every 5 cycles.
- Alternating owner reads with READ_LATENCY=3 (p0 @0x0=0xA, p1 @0x4=0xB, p0 @0x8=0xC) → rvalid pulses 3 cycles after each grant, on p0/p1/p0 in order, with 0xA/0xB/0xC.
- Assert reset while 2 reads are in flight → no rvalid afterward, all outputs 0, counter 0; first post-reset p0 read returns normally.
- With DM_ARB_STATS_EN, 10 cycles of both requesting, STARVE_LIMIT=4 → stat_conflicts=10, stat_forced=2.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares a single-port data memory between the pipeline
// memory stage (port 0, fixed priority) and a secondary master (port 1) that
// is guaranteed forward progress by a starvation counter. Read data is routed
// back to its owner through a READ_LATENCY-deep tag pipeline.
// Optional build macro: DM_ARB_STATS_EN adds stat_conflicts / stat_forced.
module data_memory_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef DM_ARB_STATS_EN
    output logic [31:0]       stat_conflicts,
    output logic [31:0]       stat_forced,
`endif
    output logic              stall
);

    localparam int unsigned       CNT_W = 4;
    localparam int unsigned       LAST  = READ_LATENCY - 1;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    logic                    force_p1;
    logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
    logic [READ_LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [READ_LATENCY-1:0] tag_owner_q, tag_owner_d;
    logic [ADDR_W-1:0]       last_addr_q, last_addr_d;
    logic [DATA_W-1:0]       p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]       p1_rdata_q, p1_rdata_d;

    // Arbitration, memory mux, starvation counter, tag shift and read routing
    always_comb begin
        force_p1 = (starve_cnt_q == LIMIT) && p1_req;
        p1_gnt   = !reset && p1_req && (!p0_req || force_p1);
        p0_gnt   = !reset && p0_req && !p1_gnt;
        stall    = !reset && p0_req && !p0_gnt;

        mem_we    = 1'b0;
        mem_addr  = last_addr_q;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
        last_addr_d = mem_addr;

        starve_cnt_d = '0;
        if (p1_req && !p1_gnt) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end

        tag_valid_d    = '0;
        tag_owner_d    = '0;
        tag_valid_d[0] = (p0_gnt || p1_gnt) && !mem_we;
        tag_owner_d[0] = p1_gnt;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_owner_d[i] = tag_owner_q[i-1];
        end

        p0_rvalid  = tag_valid_q[LAST] && !tag_owner_q[LAST];
        p1_rvalid  = tag_valid_q[LAST] && tag_owner_q[LAST];
        p0_rdata   = p0_rvalid ? mem_rdata : p0_rdata_q;
        p1_rdata   = p1_rvalid ? mem_rdata : p1_rdata_q;
        p0_rdata_d = p0_rdata;
        p1_rdata_d = p1_rdata;
    end

    // State registers; reset flushes in-flight read tags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            tag_valid_q  <= '0;
            tag_owner_q  <= '0;
            last_addr_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_owner_q  <= tag_owner_d;
            last_addr_q  <= last_addr_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

`ifdef DM_ARB_STATS_EN
    logic [31:0] conflicts_q, conflicts_d;
    logic [31:0] forced_q, forced_d;

    // Count contention cycles and port-1 grants won over a competing port 0
    always_comb begin
        conflicts_d = conflicts_q;
        forced_d    = forced_q;
        if (p0_req && p1_req) begin
            conflicts_d = conflicts_q + 32'd1;
        end
        if (p1_gnt && force_p1 && p0_req) begin
            forced_d = forced_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflicts_q <= '0;
            forced_q    <= '0;
        end else begin
            conflicts_q <= conflicts_d;
            forced_q    <= forced_d;
        end
    end

    assign stat_conflicts = conflicts_q;
    assign stat_forced    = forced_q;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed table, corner-case
// sequences and randomized traffic against a transaction-level model.
module tb_data_memory_arbiter;

    localparam int RL = 3;
    localparam int SL = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we, stall;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DM_ARB_STATS_EN
    logic [31:0] stat_conflicts, stat_forced;
    logic [31:0] m_conf, m_forced;
`endif

    always #5 clock = ~clock;

    data_memory_arbiter #(
        .ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef DM_ARB_STATS_EN
        .stat_conflicts(stat_conflicts), .stat_forced(stat_forced),
`endif
        .stall(stall)
    );

    // Synchronous memory: data for the address seen at an edge appears RL cycles later
    logic        mem_init = 1'b1;
    logic [31:0] memarr [256];
    logic [31:0] rd_pipe [RL];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) memarr[i] <= '0;
        end else if (mem_we) begin
            memarr[mem_addr[9:2]] <= mem_wdata;
        end
        rd_pipe[0] <= memarr[mem_addr[9:2]];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic eg0, eg1, est, erv0, erv1;
        logic [31:0] erd0, erd1;
    } vec_t;

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } ret_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    logic        m_g0, m_g1;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;
    logic [31:0] model_mem [256];
    ret_t        rq [$];
    vec_t        tbl [16];

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t row(input logic [31:0] r0, w0, a0, d0, r1, w1, a1, d1,
                                 eg0, eg1, est, erv0, erv1, erd0, erd1);
        vec_t v;
        v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = a0; v.d0 = d0;
        v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = a1; v.d1 = d1;
        v.eg0 = 1'(eg0); v.eg1 = 1'(eg1); v.est = 1'(est);
        v.erv0 = 1'(erv0); v.erv1 = 1'(erv1); v.erd0 = erd0; v.erd1 = erd1;
        return v;
    endfunction

    // One cycle: compare against the model with current inputs, advance model, clock
    task automatic step();
        logic        fp, erv0, erv1, gwe;
        logic [31:0] gaddr, gwdata;
        ret_t        r;
        #1;
        fp   = (m_cnt == SL) && p1_req;
        m_g1 = p1_req && (!p0_req || fp);
        m_g0 = p0_req && !m_g1;
        check1("p0_gnt", p0_gnt, m_g0);
        check1("p1_gnt", p1_gnt, m_g1);
        check1("stall", stall, p0_req && !m_g0);
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.owner) begin erv1 = 1'b1; m_rd1 = r.data; end
            else         begin erv0 = 1'b1; m_rd0 = r.data; end
        end
        check1("p0_rvalid", p0_rvalid, erv0);
        check1("p1_rvalid", p1_rvalid, erv1);
        check32("p0_rdata", p0_rdata, m_rd0);
        check32("p1_rdata", p1_rdata, m_rd1);
        gwe    = m_g0 ? p0_we    : p1_we;
        gaddr  = m_g0 ? p0_addr  : p1_addr;
        gwdata = m_g0 ? p0_wdata : p1_wdata;
        if (m_g0 || m_g1) begin
            check1("mem_we", mem_we, gwe);
            check32("mem_addr", mem_addr, gaddr);
            if (gwe) begin
                check32("mem_wdata", mem_wdata, gwdata);
                model_mem[gaddr[9:2]] = gwdata;
            end else begin
                rq.push_back('{cyc + RL, m_g1, model_mem[gaddr[9:2]]});
            end
        end else begin
            check1("mem_we_idle", mem_we, 1'b0);
        end
`ifdef DM_ARB_STATS_EN
        if (p0_req && p1_req) m_conf = m_conf + 32'd1;
        if (m_g1 && p0_req) m_forced = m_forced + 32'd1;
`endif
        if (p1_req && !m_g1) m_cnt = (m_cnt == SL) ? m_cnt : m_cnt + 1;
        else                 m_cnt = 0;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle();
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    // Hold reset with both ports requesting writes; every output must read 0
    task automatic do_reset(input int n);
        reset = 1'b1;
        p0_req = 1'b1; p0_we = 1'b1; p1_req = 1'b1; p1_we = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            check1("rst_p0_gnt", p0_gnt, 1'b0);
            check1("rst_p1_gnt", p1_gnt, 1'b0);
            check1("rst_mem_we", mem_we, 1'b0);
            check1("rst_stall", stall, 1'b0);
            check1("rst_p0_rvalid", p0_rvalid, 1'b0);
            check1("rst_p1_rvalid", p1_rvalid, 1'b0);
            check32("rst_p0_rdata", p0_rdata, 32'h0);
            check32("rst_p1_rdata", p1_rdata, 32'h0);
`ifdef DM_ARB_STATS_EN
            check32("rst_stat_conflicts", stat_conflicts, 32'h0);
            check32("rst_stat_forced", stat_forced, 32'h0);
`endif
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        idle();
        p0_we = 1'b0; p1_we = 1'b0;
        rq.delete();
        m_cnt = 0; m_rd0 = '0; m_rd1 = '0;
`ifdef DM_ARB_STATS_EN
        m_conf = '0; m_forced = '0;
`endif
    endtask

    initial begin
        logic p0_pend, p1_pend;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;

        //        r0 w0 a0     d0            r1 w1 a1     d1    g0 g1 st rv0 rv1 rd0           rd1
        tbl[0]  = row(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0,     0,    1, 0, 0, 0, 0, 0,            0);
        tbl[1]  = row(1, 0, 32'h10, 0,            0, 0, 0,     0,    1, 0, 0, 0, 0, 0,            0);
        tbl[2]  = row(0, 0, 0,      0,            1, 1, 32'h20, 1,   0, 1, 0, 0, 0, 0,            0);
        tbl[3]  = row(0, 0, 0,      0,            1, 1, 32'h24, 2,   0, 1, 0, 0, 0, 0,            0);
        tbl[4]  = row(0, 0, 0,      0,            1, 0, 32'h20, 0,   0, 1, 0, 1, 0, 32'hDEADBEEF, 0);
        tbl[5]  = row(0, 0, 0,      0,            1, 0, 32'h24, 0,   0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        tbl[6]  = row(1, 1, 32'h0,  32'hA,        0, 0, 0,     0,    1, 0, 0, 0, 0, 32'hDEADBEEF, 0);
        tbl[7]  = row(0, 0, 0,      0,            1, 1, 32'h4, 32'hB, 0, 1, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[8]  = row(1, 1, 32'h8,  32'hC,        0, 0, 0,     0,    1, 0, 0, 0, 1, 32'hDEADBEEF, 2);
        tbl[9]  = row(1, 0, 32'h0,  0,            0, 0, 0,     0,    1, 0, 0, 0, 0, 32'hDEADBEEF, 2);
        tbl[10] = row(0, 0, 0,      0,            1, 0, 32'h4, 0,    0, 1, 0, 0, 0, 32'hDEADBEEF, 2);
        tbl[11] = row(1, 0, 32'h8,  0,            0, 0, 0,     0,    1, 0, 0, 0, 0, 32'hDEADBEEF, 2);
        tbl[12] = row(0, 0, 0,      0,            0, 0, 0,     0,    0, 0, 0, 1, 0, 32'hA,        2);
        tbl[13] = row(0, 0, 0,      0,            0, 0, 0,     0,    0, 0, 0, 0, 1, 32'hA,        32'hB);
        tbl[14] = row(0, 0, 0,      0,            0, 0, 0,     0,    0, 0, 0, 1, 0, 32'hC,        32'hB);
        tbl[15] = row(0, 0, 0,      0,            0, 0, 0,     0,    0, 0, 0, 0, 0, 32'hC,        32'hB);

        @(posedge clock);
        #1;
        mem_init = 1'b0;
        do_reset(2);

        // Directed table: single-port writes/reads, back-to-back and alternating owners
        for (int i = 0; i < 16; i++) begin
            p0_req = tbl[i].r0; p0_we = tbl[i].w0; p0_addr = tbl[i].a0; p0_wdata = tbl[i].d0;
            p1_req = tbl[i].r1; p1_we = tbl[i].w1; p1_addr = tbl[i].a1; p1_wdata = tbl[i].d1;
            #1;
            check1("tbl_p0_gnt", p0_gnt, tbl[i].eg0);
            check1("tbl_p1_gnt", p1_gnt, tbl[i].eg1);
            check1("tbl_stall", stall, tbl[i].est);
            check1("tbl_p0_rvalid", p0_rvalid, tbl[i].erv0);
            check1("tbl_p1_rvalid", p1_rvalid, tbl[i].erv1);
            check32("tbl_p0_rdata", p0_rdata, tbl[i].erd0);
            check32("tbl_p1_rdata", p1_rdata, tbl[i].erd1);
            step();
        end

        // Continuous contention: port 1 forced every fifth cycle
        for (int k = 0; k < 10; k++) begin
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'(k);
            p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h44; p1_wdata = 32'h55;
            #1;
            check1("starve_p1_gnt", p1_gnt, (k % 5) == 4);
            check1("starve_p0_gnt", p0_gnt, (k % 5) != 4);
            check1("starve_stall", stall, (k % 5) == 4);
            step();
        end
`ifdef DM_ARB_STATS_EN
        check32("stat_conflicts", stat_conflicts, 32'd10);
        check32("stat_forced", stat_forced, 32'd2);
        check32("stat_conflicts_model", stat_conflicts, m_conf);
`endif

        // Two reads in flight, then reset flushes them
        idle();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        step();
        idle();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
        step();
        do_reset(2);
        for (int k = 0; k < 5; k++) begin
            #1;
            check1("flush_p0_rvalid", p0_rvalid, 1'b0);
            check1("flush_p1_rvalid", p1_rvalid, 1'b0);
            step();
        end

        // First read after reset returns normally
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        step();
        idle();
        step();
        step();
        #1;
        check1("post_rst_rvalid", p0_rvalid, 1'b1);
        check32("post_rst_rdata", p0_rdata, 32'hDEADBEEF);
        step();

        // Randomized traffic obeying the hold-until-granted rule
        p0_pend = 1'b0;
        p1_pend = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!p0_pend && $urandom_range(0, 99) < 60) begin
                p0_pend  = 1'b1;
                p0_we    = 1'($urandom_range(0, 1));
                p0_addr  = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
                p0_wdata = $urandom;
            end
            if (!p1_pend && $urandom_range(0, 99) < 50) begin
                p1_pend  = 1'b1;
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
                p1_wdata = $urandom;
            end
            p0_req = p0_pend;
            p1_req = p1_pend;
            step();
            if (m_g0) p0_pend = 1'b0;
            if (m_g1) p1_pend = 1'b0;
        end
        idle();
        for (int k = 0; k < RL + 2; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
